ambiente_robo: RTL and testbench
================================

Name: ambiente_robo

Overview:
- Environment/world model for the robot controller FSM; the other end of the robot's sensor/command interface.
- Keeps a GRID_W x GRID_H cell map plus the robot's position and heading.
- Consumes the robot's avancar/girar/recolher_entulho commands and produces the head/left/under/barrier sensor signals and current heading the controller reads.
- Used as the closed-loop bench partner and as the on-board simulated arena.

Parameters:
GRID_W, 8, map width in cells (power of 2, 2..16)
GRID_H, 8, map height in cells (power of 2, 2..16)
START_X, 0, initial column
START_Y, 0, initial row
START_DIR, 2'b00, initial heading (00 N, 01 O, 10 S, 11 L)
REMOVE_CYCLES, 4, clocks to clear one rubble cell (>=1)

Ports:
clock  in  1  system clock; all state updates on posedge
reset  in  1  asynchronous, active-high
map_we  in  1  map write strobe (honoured only in LOAD)
map_x  in  log2(GRID_W)  write column
map_y  in  log2(GRID_H)  write row
map_data  in  2  cell code: 00 free, 01 wall, 10 rubble, 11 mark
start  in  1  one-cycle pulse: place robot, enter RUN
avancar  in  1  move one cell forward
girar  in  1  rotate heading
recolher_entulho  in  1  remove rubble ahead
head  out  1  cell ahead is wall or off-grid
left  out  1  cell to the left is wall or off-grid
under  out  1  current cell is mark
barrier  out  1  cell ahead is rubble
direcao  out  2  current heading, feeds robot direcao_input
pos_x  out  log2(GRID_W)  current column
pos_y  out  log2(GRID_H)  current row
busy  out  1  high in REMOVING
collision  out  1  sticky; forward move into wall/rubble/off-grid attempted
cmd_error  out  1  sticky; more than one command high in one cycle
steps  out  16  count of executed moves, saturating at 16'hFFFF

Behaviour:
- Reset values:
  - state = LOAD; all cells = 00.
  - pos = (START_X, START_Y); direcao = START_DIR.
  - busy, collision, cmd_error = 0; steps = 0.
- Direction vectors: N y+1, S y-1, L x+1, O x-1. The left of heading d is (d+1) mod 4.
- Sensors are combinational from registered pos, direcao and map. They are stable from posedge to posedge; the robot samples them on negedge. Any off-grid neighbour counts as wall.
- LOAD state:
  - map_we writes map[map_x][map_y] = map_data; commands are ignored.
  - start: pos = START, direcao = START_DIR, steps = 0, collision = 0, cmd_error = 0, then go to RUN. Map contents are kept.
- RUN state: commands are sampled on each posedge, one action per cycle.
  - Exactly one command high:
    - girar: direcao <= direcao+1 mod 4.
    - avancar with target free or mark: pos <= target, steps+1.
    - avancar with target wall, rubble or off-grid: pos unchanged, collision <= 1.
    - recolher_entulho with barrier=1: go to REMOVING, load counter with REMOVE_CYCLES-1, busy <= 1.
    - recolher_entulho with barrier=0: no-op.
  - Two or more commands high: no action, cmd_error <= 1.
  - start in RUN: re-place the robot as in LOAD; stay in RUN.
  - map_we in RUN is ignored.
- REMOVING state:
  - Counter decrements each clock; commands are ignored and do not set cmd_error.
  - When counter = 0: the cell ahead (captured at entry) <= 00, busy <= 0, return to RUN. barrier drops the following cycle.
  - Total busy duration = REMOVE_CYCLES clocks.
  - start during REMOVING is ignored.
- steps saturates at 16'hFFFF. Coordinates never wrap; off-grid moves are collisions.
- Reset asserted mid-REMOVING or mid-RUN: immediate return to the reset values. The map is cleared and must be reloaded.

Test Plan:
- Reset, load an empty 8x8 map, start; apply avancar x3 -> pos (0,3), direcao 00, steps 3, head 0; at (0,0) facing N, left=1 (off-grid west).
- At (0,0) facing N, girar x4 -> direcao sequence 01,10,11,00; after the first girar head=1 (west off-grid).
- Wall at (0,1), robot at (0,0) facing N -> head=1; avancar -> pos stays (0,0), collision=1, steps 0.
- Rubble at (0,1), REMOVE_CYCLES=4 -> barrier=1; recolher_entulho -> busy high 4 clocks, avancar during busy ignored; then barrier=0, map(0,1)=00; avancar -> pos (0,1).
- Mark at (0,1); avancar -> under=1. Same cycle avancar+girar -> no move, cmd_error=1.
- Closed loop with the robot FSM on a 4x4 arena with one rubble cell -> no collision, rubble cleared; reset mid-REMOVING -> busy=0, pos START, map all 00.

Source files
------------

// File: rtl/ambiente_robo_if.sv
// ambiente_robo_if: signal bundle between the robot controller (master) and
// the environment model (slave).
//   master drives : map_we, map_x, map_y, map_data, start,
//                   avancar, girar, recolher_entulho
//   slave drives  : head, left, under, barrier, direcao, pos_x, pos_y,
//                   busy, collision, cmd_error, steps, state_dbg
// Handshake: there is no valid/ready pair. Every master input is a level
// sampled on each rising clock edge. Every slave output is stable from one
// rising edge to the next, so the master may sample it on the falling edge.
interface ambiente_robo_if #(
  parameter int XW = 3,
  parameter int YW = 3
);
  logic          map_we;
  logic [XW-1:0] map_x;
  logic [YW-1:0] map_y;
  logic [1:0]    map_data;
  logic          start;
  logic          avancar;
  logic          girar;
  logic          recolher_entulho;

  logic          head;
  logic          left;
  logic          under;
  logic          barrier;
  logic [1:0]    direcao;
  logic [XW-1:0] pos_x;
  logic [YW-1:0] pos_y;
  logic          busy;
  logic          collision;
  logic          cmd_error;
  logic [15:0]   steps;
  logic [1:0]    state_dbg;

  modport master (
    output map_we, map_x, map_y, map_data, start, avancar, girar, recolher_entulho,
    input  head, left, under, barrier, direcao, pos_x, pos_y,
           busy, collision, cmd_error, steps, state_dbg
  );

  modport slave (
    input  map_we, map_x, map_y, map_data, start, avancar, girar, recolher_entulho,
    output head, left, under, barrier, direcao, pos_x, pos_y,
           busy, collision, cmd_error, steps, state_dbg
  );
endinterface

// File: rtl/ambiente_robo.sv
// ambiente_robo: grid world for the robot controller.
// It holds a GRID_W x GRID_H map of 2-bit cells (00 free, 01 wall, 10 rubble,
// 11 mark), plus the robot's position and heading. It executes the commands
// avancar, girar and recolher_entulho, and reports the sensors.
// Ports:
//   clock     : all state updates happen on the rising edge
//   reset     : asynchronous, active-high; clears the map and all state
//   bus.slave : map load, command inputs, sensor/status outputs
//               (see ambiente_robo_if)
// Headings: 00 N (y+1), 01 O (x-1), 10 S (y-1), 11 L (x+1).
// The heading to the left of d is d+1 mod 4.
module ambiente_robo #(
  parameter int         GRID_W        = 8,
  parameter int         GRID_H        = 8,
  parameter int         START_X       = 0,
  parameter int         START_Y       = 0,
  parameter logic [1:0] START_DIR     = 2'b00,
  parameter int         REMOVE_CYCLES = 4
) (
  input  logic           clock,
  input  logic           reset,
  ambiente_robo_if.slave bus
);
  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam int CW = $clog2(REMOVE_CYCLES + 1);

  localparam logic [1:0] C_FREE   = 2'b00;
  localparam logic [1:0] C_WALL   = 2'b01;
  localparam logic [1:0] C_RUBBLE = 2'b10;
  localparam logic [1:0] C_MARK   = 2'b11;

  typedef enum logic [1:0] {
    S_LOAD     = 2'd0,
    S_RUN      = 2'd1,
    S_REMOVING = 2'd2
  } state_t;

  // Neighbour of a cell in a given heading. When the neighbour would fall off
  // the grid, off is set and x/y keep the source cell, so the index stays legal.
  typedef struct packed {
    logic          off;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } nbr_t;

  function automatic nbr_t nbr(input logic [XW-1:0] x, input logic [YW-1:0] y,
                               input logic [1:0] d);
    nbr_t r;
    r.off = 1'b0;
    r.x   = x;
    r.y   = y;
    case (d)
      2'b00: if (y == YW'(GRID_H - 1)) r.off = 1'b1; else r.y = y + YW'(1);
      2'b01: if (x == '0)              r.off = 1'b1; else r.x = x - XW'(1);
      2'b10: if (y == '0)              r.off = 1'b1; else r.y = y - YW'(1);
      default: if (x == XW'(GRID_W - 1)) r.off = 1'b1; else r.x = x + XW'(1);
    endcase
    return r;
  endfunction

  state_t        state_q, state_d;
  logic [1:0]    map_q [GRID_W][GRID_H];
  logic [1:0]    map_d [GRID_W][GRID_H];
  logic [XW-1:0] pos_x_q, pos_x_d;
  logic [YW-1:0] pos_y_q, pos_y_d;
  logic [1:0]    dir_q, dir_d;
  logic          busy_q, busy_d;
  logic          coll_q, coll_d;
  logic          err_q, err_d;
  logic [15:0]   steps_q, steps_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XW-1:0] rm_x_q, rm_x_d;
  logic [YW-1:0] rm_y_q, rm_y_d;

  nbr_t       ahead;
  nbr_t       lft;
  logic [1:0] ahead_code;
  logic       multi_cmd;

  assign ahead      = nbr(pos_x_q, pos_y_q, dir_q);
  assign lft        = nbr(pos_x_q, pos_y_q, dir_q + 2'd1);
  assign ahead_code = map_q[ahead.x][ahead.y];
  assign multi_cmd  = (bus.avancar & bus.girar) | (bus.avancar & bus.recolher_entulho) |
                      (bus.girar & bus.recolher_entulho);

  // Sensors come only from registered state, so they hold steady for a full clock.
  assign bus.head      = ahead.off | (ahead_code == C_WALL);
  assign bus.left      = lft.off | (map_q[lft.x][lft.y] == C_WALL);
  assign bus.under     = (map_q[pos_x_q][pos_y_q] == C_MARK);
  assign bus.barrier   = ~ahead.off & (ahead_code == C_RUBBLE);
  assign bus.direcao   = dir_q;
  assign bus.pos_x     = pos_x_q;
  assign bus.pos_y     = pos_y_q;
  assign bus.busy      = busy_q;
  assign bus.collision = coll_q;
  assign bus.cmd_error = err_q;
  assign bus.steps     = steps_q;
  assign bus.state_dbg = state_q;

  always_comb begin
    state_d = state_q;
    map_d   = map_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    dir_d   = dir_q;
    busy_d  = busy_q;
    coll_d  = coll_q;
    err_d   = err_q;
    steps_d = steps_q;
    cnt_d   = cnt_q;
    rm_x_d  = rm_x_q;
    rm_y_d  = rm_y_q;

    case (state_q)
      S_LOAD: begin
        if (bus.map_we) map_d[bus.map_x][bus.map_y] = bus.map_data;
        if (bus.start) begin
          pos_x_d = XW'(START_X);
          pos_y_d = YW'(START_Y);
          dir_d   = START_DIR;
          steps_d = '0;
          coll_d  = 1'b0;
          err_d   = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // A start pulse takes priority over any command in the same cycle.
        if (bus.start) begin
          pos_x_d = XW'(START_X);
          pos_y_d = YW'(START_Y);
          dir_d   = START_DIR;
          steps_d = '0;
          coll_d  = 1'b0;
          err_d   = 1'b0;
        end else if (multi_cmd) begin
          err_d = 1'b1;
        end else if (bus.girar) begin
          dir_d = dir_q + 2'd1;
        end else if (bus.avancar) begin
          if (!ahead.off && (ahead_code == C_FREE || ahead_code == C_MARK)) begin
            pos_x_d = ahead.x;
            pos_y_d = ahead.y;
            if (steps_q != 16'hFFFF) steps_d = steps_q + 16'd1;
          end else begin
            coll_d = 1'b1;
          end
        end else if (bus.recolher_entulho) begin
          if (!ahead.off && ahead_code == C_RUBBLE) begin
            // Latch the target cell so the clear still hits it at the end.
            rm_x_d  = ahead.x;
            rm_y_d  = ahead.y;
            cnt_d   = CW'(REMOVE_CYCLES - 1);
            busy_d  = 1'b1;
            state_d = S_REMOVING;
          end
        end
      end
      S_REMOVING: begin
        if (cnt_q == '0) begin
          map_d[rm_x_q][rm_y_q] = C_FREE;
          busy_d  = 1'b0;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_LOAD;
      for (int i = 0; i < GRID_W; i++)
        for (int j = 0; j < GRID_H; j++)
          map_q[i][j] <= C_FREE;
      pos_x_q <= XW'(START_X);
      pos_y_q <= YW'(START_Y);
      dir_q   <= START_DIR;
      busy_q  <= 1'b0;
      coll_q  <= 1'b0;
      err_q   <= 1'b0;
      steps_q <= '0;
      cnt_q   <= '0;
      rm_x_q  <= '0;
      rm_y_q  <= '0;
    end else begin
      state_q <= state_d;
      map_q   <= map_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      coll_q  <= coll_d;
      err_q   <= err_d;
      steps_q <= steps_d;
      cnt_q   <= cnt_d;
      rm_x_q  <= rm_x_d;
      rm_y_q  <= rm_y_d;
    end
  end
endmodule

// File: tb/tb_ambiente_robo.sv
// Bench for ambiente_robo on an 8x8 grid with REMOVE_CYCLES = 4.
// It runs four phases:
//   1. A directed vector table.
//   2. Hand-written corner sequences: wall, rubble removal, mark,
//      command clash, and reset during a removal.
//   3. Randomized rounds checked every cycle against a world model
//      built from the movement rules.
//   4. A final summary.
module tb_ambiente_robo;
  localparam int GW = 8;
  localparam int GH = 8;
  localparam int RC = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  ambiente_robo_if #(.XW(3), .YW(3)) bus ();

  ambiente_robo #(
    .GRID_W(GW), .GRID_H(GH), .START_X(0), .START_Y(0),
    .START_DIR(2'b00), .REMOVE_CYCLES(RC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // World model: map, robot pose, and remaining removal clocks.
  int m_map [GW][GH];
  int m_x, m_y, m_dir, m_steps, m_coll, m_err;
  int m_mode;          // 0 loading, 1 running, 2 removing
  int m_left, m_rmx, m_rmy;
  int dx [4] = '{0, -1, 0, 1};
  int dy [4] = '{1, 0, -1, 0};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int cell_at(input int x, input int y);
    if (x < 0 || x >= GW || y < 0 || y >= GH) return -1;
    return m_map[x][y];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < GW; i++)
      for (int j = 0; j < GH; j++)
        m_map[i][j] = 0;
    m_x = 0; m_y = 0; m_dir = 0; m_steps = 0; m_coll = 0; m_err = 0;
    m_mode = 0; m_left = 0;
  endtask

  task automatic model_place();
    m_x = 0; m_y = 0; m_dir = 0; m_steps = 0; m_coll = 0; m_err = 0;
  endtask

  task automatic model_step(input int we, input int mx, input int my, input int md,
                            input int st, input int av, input int gi, input int re);
    int nx, ny, c;
    nx = m_x + dx[m_dir];
    ny = m_y + dy[m_dir];
    c  = cell_at(nx, ny);
    if (m_mode == 0) begin
      if (we != 0) m_map[mx][my] = md;
      if (st != 0) begin model_place(); m_mode = 1; end
    end else if (m_mode == 1) begin
      if (st != 0) model_place();
      else if (av + gi + re > 1) m_err = 1;
      else if (gi != 0) m_dir = (m_dir + 1) % 4;
      else if (av != 0) begin
        if (c == 0 || c == 3) begin
          m_x = nx; m_y = ny;
          if (m_steps < 65535) m_steps++;
        end else m_coll = 1;
      end else if (re != 0 && c == 2) begin
        m_mode = 2; m_left = RC; m_rmx = nx; m_rmy = ny;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin m_map[m_rmx][m_rmy] = 0; m_mode = 1; end
    end
  endtask

  task automatic check_model();
    int ca, cl;
    ca = cell_at(m_x + dx[m_dir], m_y + dy[m_dir]);
    cl = cell_at(m_x + dx[(m_dir + 1) % 4], m_y + dy[(m_dir + 1) % 4]);
    chk("pos_x", int'(bus.pos_x), m_x);
    chk("pos_y", int'(bus.pos_y), m_y);
    chk("direcao", int'(bus.direcao), m_dir);
    chk("head", int'(bus.head), int'(ca == -1 || ca == 1));
    chk("left", int'(bus.left), int'(cl == -1 || cl == 1));
    chk("under", int'(bus.under), int'(m_map[m_x][m_y] == 3));
    chk("barrier", int'(bus.barrier), int'(ca == 2));
    chk("busy", int'(bus.busy), int'(m_mode == 2));
    chk("collision", int'(bus.collision), m_coll);
    chk("cmd_error", int'(bus.cmd_error), m_err);
    chk("steps", int'(bus.steps), m_steps);
  endtask

  // Drive one cycle of inputs, clock it, advance the model, then compare.
  task automatic apply(input int we, input int mx, input int my, input int md,
                       input int st, input int av, input int gi, input int re);
    bus.map_we           = we[0];
    bus.map_x            = mx[2:0];
    bus.map_y            = my[2:0];
    bus.map_data         = md[1:0];
    bus.start            = st[0];
    bus.avancar          = av[0];
    bus.girar            = gi[0];
    bus.recolher_entulho = re[0];
    @(posedge clock);
    cyc++;
    model_step(we, mx, my, md, st, av, gi, re);
    #1;
    check_model();
  endtask

  task automatic idle();
    apply(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    #1;
    model_reset();
    check_model();
    chk("reset state_dbg", int'(bus.state_dbg), 0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic load_cell(input int x, input int y, input int code);
    apply(1, x, y, code, 0, 0, 0, 0);
  endtask

  typedef struct {
    int st, av, gi, re;
    int ex, ey, edir, ehead, eleft, esteps, ecoll, eerr;
  } vec_t;
  vec_t vt [12];

  initial begin
    bus.map_we = 0; bus.map_x = 0; bus.map_y = 0; bus.map_data = 0;
    bus.start = 0; bus.avancar = 0; bus.girar = 0; bus.recolher_entulho = 0;

    // Directed table on an empty map: start, move north, turn, clash, collide.
    //          st av gi re  x  y dir hd lf st co er
    vt[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    vt[1]  = '{0, 1, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0};
    vt[2]  = '{0, 1, 0, 0, 0, 2, 0, 0, 1, 2, 0, 0};
    vt[3]  = '{0, 1, 0, 0, 0, 3, 0, 0, 1, 3, 0, 0};
    vt[4]  = '{0, 0, 1, 0, 0, 3, 1, 1, 0, 3, 0, 0};
    vt[5]  = '{0, 0, 1, 0, 0, 3, 2, 0, 0, 3, 0, 0};
    vt[6]  = '{0, 0, 1, 0, 0, 3, 3, 0, 0, 3, 0, 0};
    vt[7]  = '{0, 0, 1, 0, 0, 3, 0, 0, 1, 3, 0, 0};
    vt[8]  = '{0, 1, 1, 0, 0, 3, 0, 0, 1, 3, 0, 1};
    vt[9]  = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    vt[10] = '{0, 0, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0};
    vt[11] = '{0, 1, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      apply(0, 0, 0, 0, vt[i].st, vt[i].av, vt[i].gi, vt[i].re);
      chk($sformatf("vec%0d pos_x", i), int'(bus.pos_x), vt[i].ex);
      chk($sformatf("vec%0d pos_y", i), int'(bus.pos_y), vt[i].ey);
      chk($sformatf("vec%0d dir", i), int'(bus.direcao), vt[i].edir);
      chk($sformatf("vec%0d head", i), int'(bus.head), vt[i].ehead);
      chk($sformatf("vec%0d left", i), int'(bus.left), vt[i].eleft);
      chk($sformatf("vec%0d steps", i), int'(bus.steps), vt[i].esteps);
      chk($sformatf("vec%0d coll", i), int'(bus.collision), vt[i].ecoll);
      chk($sformatf("vec%0d err", i), int'(bus.cmd_error), vt[i].eerr);
    end

    // Wall straight ahead: the move is refused and collision is flagged.
    do_reset();
    load_cell(0, 1, 1);
    apply(0, 0, 0, 0, 1, 0, 0, 0);
    chk("wall head", int'(bus.head), 1);
    apply(0, 0, 0, 0, 0, 1, 0, 0);
    chk("wall pos_y", int'(bus.pos_y), 0);
    chk("wall collision", int'(bus.collision), 1);
    chk("wall steps", int'(bus.steps), 0);

    // Rubble: busy for exactly 4 clocks, moves ignored, then the path is clear.
    do_reset();
    load_cell(0, 1, 2);
    apply(0, 0, 0, 0, 1, 0, 0, 0);
    chk("rubble barrier", int'(bus.barrier), 1);
    apply(0, 0, 0, 0, 0, 0, 0, 1);
    chk("rm busy 1", int'(bus.busy), 1);
    for (int k = 2; k <= 4; k++) begin
      apply(0, 0, 0, 0, 0, 1, 1, 0);
      chk($sformatf("rm busy %0d", k), int'(bus.busy), 1);
      chk("rm no cmd_error", int'(bus.cmd_error), 0);
    end
    apply(0, 0, 0, 0, 0, 1, 0, 0);
    chk("rm busy end", int'(bus.busy), 0);
    chk("rm barrier clear", int'(bus.barrier), 0);
    chk("rm pos unchanged", int'(bus.pos_y), 0);
    apply(0, 0, 0, 0, 0, 1, 0, 0);
    chk("rm move pos_y", int'(bus.pos_y), 1);

    // Mark cell, then two commands at once.
    do_reset();
    load_cell(0, 1, 3);
    apply(0, 0, 0, 0, 1, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 1, 0, 0);
    chk("mark under", int'(bus.under), 1);
    apply(0, 0, 0, 0, 0, 1, 1, 0);
    chk("clash pos_y", int'(bus.pos_y), 1);
    chk("clash cmd_error", int'(bus.cmd_error), 1);

    // Reset in the middle of a removal wipes the map and the pose.
    do_reset();
    load_cell(0, 1, 2);
    load_cell(3, 3, 1);
    apply(0, 0, 0, 0, 1, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    chk("pre-reset busy", int'(bus.busy), 1);
    do_reset();
    chk("mid-rm reset busy", int'(bus.busy), 0);
    apply(0, 0, 0, 0, 1, 0, 0, 0);
    chk("map cleared barrier", int'(bus.barrier), 0);

    // Randomized rounds against the model.
    for (int round = 0; round < 3; round++) begin
      do_reset();
      for (int n = 0; n < 24; n++)
        load_cell($urandom_range(0, GW - 1), $urandom_range(0, GH - 1), $urandom_range(1, 3));
      apply(0, 0, 0, 0, 1, 0, 0, 0);
      for (int n = 0; n < 300; n++) begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 30)      apply(0, 0, 0, 0, 0, 1, 0, 0);
        else if (r < 55) apply(0, 0, 0, 0, 0, 0, 1, 0);
        else if (r < 75) apply(0, 0, 0, 0, 0, 0, 0, 1);
        else if (r < 85) apply(0, 0, 0, 0, 0, $urandom_range(0, 1), 1, $urandom_range(0, 1));
        else if (r < 88) apply(0, 0, 0, 0, 1, 0, 0, 0);
        else if (r < 93) apply(1, $urandom_range(0, GW - 1), $urandom_range(0, GH - 1),
                               $urandom_range(0, 3), 0, 0, 0, 0);
        else             idle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
